// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with combinational controls.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module mc_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       illegal
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] MEM_LAST = 3'(MEM_LAT - 1);

  state_t     r_state, w_next;
  logic [2:0] r_mem_cnt, w_mem_cnt_nxt;

  logic w_rtype, w_addu, w_subu, w_jr, w_nop, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
  logic w_supported;

  assign w_rtype = (op == 6'h00);
  assign w_addu  = w_rtype && (funct == 6'h21);
  assign w_subu  = w_rtype && (funct == 6'h23);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_nop   = w_rtype && (funct == 6'h00);
  assign w_ori   = (op == 6'h0D);
  assign w_lw    = (op == 6'h23);
  assign w_sw    = (op == 6'h2B);
  assign w_beq   = (op == 6'h04);
  assign w_lui   = (op == 6'h0F);
  assign w_j     = (op == 6'h02);
  assign w_jal   = (op == 6'h03);
  assign w_supported = w_addu | w_subu | w_jr | w_nop | w_ori | w_lw | w_sw |
                       w_beq | w_lui | w_j | w_jal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_mem_cnt <= 3'd0;
    end else begin
      r_state   <= w_next;
      r_mem_cnt <= w_mem_cnt_nxt;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_mem_cnt_nxt = 3'd0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    pc_src  = 2'd0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    alu_op  = 2'd0;
    illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_we  = 1'b1;
        pc_we  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_j || w_jal) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
          if (w_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
        end else if (w_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
        end else if (w_nop) begin
          w_next = S_FETCH;
        end else if (!w_supported) begin
          illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_subu || w_beq) alu_op = 2'd1;
        else if (w_ori)      alu_op = 2'd2;
        else if (w_lui)      alu_op = 2'd3;
        alu_src = w_ori | w_lui | w_lw | w_sw;
        ext_op  = w_lw | w_sw;
        if (w_beq) begin
          pc_we  = zero;
          pc_src = 2'd1;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // Counter runs 0..MEM_LAT-1; the store strobe lands on the final count only.
        if (r_mem_cnt == MEM_LAST) begin
          mem_we = w_sw;
          w_next = w_lw ? S_WB : S_FETCH;
        end else begin
          w_next        = S_MEM;
          w_mem_cnt_nxt = r_mem_cnt + 3'd1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = w_rtype ? 2'd1 : 2'd0;
        wd_sel  = w_lw ? 2'd1 : 2'd0;
      end
      default: w_next = S_FETCH;
    endcase
    // FETCH outputs are state-only, so reset must explicitly mask them.
    if (!reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
    end
  end

  assign state = r_state;

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_instr_cnt;
  logic        w_retire;

  assign w_retire = (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) &&
                    (w_next == S_FETCH) && !illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl (MEM_LAT=3): stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares them.
module tb_mc_ctrl;
  localparam int LAT = 3;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       pc_we, ir_we, reg_we, mem_we, alu_src, ext_op, illegal;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_op;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
    .pc_src(pc_src), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op),
    .state(state), .illegal(illegal)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pc, rg, mw;
    logic [1:0] ps, rd, wd;
    logic       as, eo;
    logic [1:0] ao;
    logic       il;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  v;
  } sb_t;

  sb_t q[$];
  int  nvec = 0;
  int  nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int st, bit ir, bit pc, bit rg, bit mw, int ps, int rd, int wd,
                              bit as, bit eo, int ao, bit il);
    exp_t e;
    e.st = 3'(st); e.ir = ir; e.pc = pc; e.rg = rg; e.mw = mw;
    e.ps = 2'(ps); e.rd = 2'(rd); e.wd = 2'(wd);
    e.as = as; e.eo = eo; e.ao = 2'(ao); e.il = il;
    return e;
  endfunction

  task automatic push(input string nm, input exp_t v);
    sb_t s;
    s.nm = nm;
    s.v  = v;
    q.push_back(s);
  endtask

  // Drive an instruction word and let it run for n cycles.
  task automatic ins(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
    op = o; funct = f; zero = z;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t  s;
      exp_t got;
      s   = q.pop_front();
      got = {state, ir_we, pc_we, reg_we, mem_we, pc_src, reg_dst, wd_sel,
             alu_src, ext_op, alu_op, illegal};
      nvec++;
      if (got !== s.v) begin
        nerr++;
        $display("FAIL %s: got st=%0d ctl=%h, want st=%0d ctl=%h",
                 s.nm, got.st, got[14:0], s.v.st, s.v[14:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  exp_t R, F, D0, WB_R, WB_I, M0, EX_LS;

  initial begin
    //     st ir pc rg mw ps rd wd as eo ao il
    R     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    F     = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    D0    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    WB_R  = mk(4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    WB_I  = mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    M0    = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EX_LS = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0;
    @(posedge clk); #1;
    push("reset", R);
    @(posedge clk); #1;
    reset = 1'b1;

    // addu, with a garbage opcode during FETCH that must be ignored
    push("addu_F", F); push("addu_D", D0);
    push("addu_EX", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); push("addu_WB", WB_R);
    ins(6'h3F, 6'h3F, 1'b0, 1);
    ins(6'h00, 6'h21, 1'b0, 3);

    push("subu_F", F); push("subu_D", D0);
    push("subu_EX", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); push("subu_WB", WB_R);
    ins(6'h00, 6'h23, 1'b0, 4);

    push("ori_F", F); push("ori_D", D0);
    push("ori_EX", mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0)); push("ori_WB", WB_I);
    ins(6'h0D, 6'h00, 1'b0, 4);

    push("lui_F", F); push("lui_D", D0);
    push("lui_EX", mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0)); push("lui_WB", WB_I);
    ins(6'h0F, 6'h00, 1'b0, 4);

    push("sw_F", F); push("sw_D", D0); push("sw_EX", EX_LS);
    push("sw_M1", M0); push("sw_M2", M0);
    push("sw_M3", mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    ins(6'h2B, 6'h00, 1'b0, 3 + LAT);

    push("lw_F", F); push("lw_D", D0); push("lw_EX", EX_LS);
    push("lw_M1", M0); push("lw_M2", M0); push("lw_M3", M0);
    push("lw_WB", mk(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    ins(6'h23, 6'h00, 1'b0, 4 + LAT);

    push("beq0_F", F); push("beq0_D", D0);
    push("beq0_EX", mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    ins(6'h04, 6'h00, 1'b0, 3);
    push("beq1_F", F); push("beq1_D", D0);
    push("beq1_EX", mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    ins(6'h04, 6'h00, 1'b1, 3);

    push("j_F", F);   push("j_D", mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    ins(6'h02, 6'h00, 1'b0, 2);
    push("jal_F", F); push("jal_D", mk(1, 0, 1, 1, 0, 2, 2, 2, 0, 0, 0, 0));
    ins(6'h03, 6'h00, 1'b0, 2);
    push("jr_F", F);  push("jr_D", mk(1, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    ins(6'h00, 6'h08, 1'b0, 2);
    push("nop_F", F); push("nop_D", D0);
    ins(6'h00, 6'h00, 1'b0, 2);

    push("ill_op_F", F);  push("ill_op_D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    ins(6'h3F, 6'h00, 1'b0, 2);
    push("ill_fn_F", F);  push("ill_fn_D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    ins(6'h00, 6'h2A, 1'b0, 2);

    // lw aborted by reset in its second MEM cycle
    push("abort_F", F); push("abort_D", D0); push("abort_EX", EX_LS); push("abort_M1", M0);
    ins(6'h23, 6'h00, 1'b0, 4);
    reset = 1'b0;
    push("abort_rst", R);
    @(posedge clk); #1;
    reset = 1'b1;

    // full lw afterwards proves the MEM counter restarted from zero
    push("lw2_F", F); push("lw2_D", D0); push("lw2_EX", EX_LS);
    push("lw2_M1", M0); push("lw2_M2", M0); push("lw2_M3", M0);
    push("lw2_WB", mk(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    ins(6'h23, 6'h00, 1'b0, 4 + LAT);

`ifdef PERF_CNT_EN
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push("pc_F", F); push("pc_D", D0);
      push("pc_EX", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); push("pc_WB", WB_R);
      ins(6'h00, 6'h21, 1'b0, 4);
    end
    nvec++;
    if (instr_cnt !== 32'd10) begin
      nerr++;
      $display("FAIL instr_cnt: got %0d, want 10", instr_cnt);
    end
    nvec++;
    if (cycle_cnt !== 32'd40) begin
      nerr++;
      $display("FAIL cycle_cnt: got %0d, want 40", cycle_cnt);
    end
`endif

    @(negedge clk); #1;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
